// File: rtl/uart_pkg.sv
// Shared UART constants: character width, FIFO depth and register-map bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_AF_LEVEL   = 12;

  // Bit positions of the sticky status flags in the status register.
  localparam int STAT_OVR  = 0;
  localparam int STAT_FERR = 1;
  localparam int STAT_W    = 2;

  typedef logic [STAT_W-1:0] uart_stat_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream into the RX FIFO (from the receiver) and the show-ahead read port out of it.
// Latency: n/a (wiring only).
// Backpressure: rd_ready stalls the read side; the receiver side has no backpressure.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              rx_error;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  // master: the receiver/consumer environment around the FIFO
  modport master (
    output rx_data, rx_done, rx_error, rd_ready,
    input  rd_data, rd_valid
  );

  // slave: the FIFO itself
  modport slave (
    input  rx_data, rx_done, rx_error, rd_ready,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array, shared by the RX and TX FIFOs.
// Latency: write lands at the clock edge; read is combinational from the address.
// Backpressure: none; the caller owns pointer and full/empty logic.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is not reset: stale entries are never visible because the
  // owning FIFO masks the read port while it is empty.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte buffer: captures bytes on rx_done into a circular FIFO, tracks occupancy and sticky errors.
// Latency: a byte written at edge N is readable in cycle N+1; no same-cycle fall-through.
// Backpressure: rd_ready holds the show-ahead output; a push while full without a pop is dropped and flags overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AF_LEVEL = UART_AF_LEVEL
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   sync_clr,
  uart_rx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   status_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  uart_stat_t        stat_q,   stat_d;

  logic              push;
  logic              pop;
  logic              mem_wr;
  logic              drop;
  logic [DATA_W-1:0] mem_rd_data;

  // Flags decode only from the registered count, so none of them has a
  // combinational path from the inputs.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign count       = count_q;
  assign overrun     = stat_q[STAT_OVR];
  assign frame_err   = stat_q[STAT_FERR];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // byte when the consumer is reading.
  assign pop    = !empty && bus.rd_ready;
  assign push   = bus.rx_done && (!full || pop);
  assign drop   = bus.rx_done && !push;
  assign mem_wr = push && !sync_clr;

  // Next-state for pointers, occupancy and sticky status; sync_clr overrides all.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stat_d   = stat_q;

    if (sync_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stat_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Set events take precedence over a coincident status_clr.
      if (drop) begin
        stat_d[STAT_OVR] = 1'b1;
      end else if (status_clr) begin
        stat_d[STAT_OVR] = 1'b0;
      end

      if (bus.rx_error) begin
        stat_d[STAT_FERR] = 1'b1;
      end else if (status_clr) begin
        stat_d[STAT_FERR] = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stat_q   <= stat_d;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (mem_wr),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.rx_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  // Show-ahead output, forced to zero while empty so stale memory never leaks.
  assign bus.rd_valid = !empty;
  assign bus.rd_data  = empty ? '0 : mem_rd_data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences, random traffic vs a queue model.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked at the same point.
// Backpressure: rd_ready driven from tables/random to exercise stalls, full and overrun.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk        = 1'b0;
  logic       areset_n   = 1'b0;
  logic       sync_clr   = 1'b0;
  logic       status_clr = 1'b0;
  logic [4:0] count;
  logic       empty, full, almost_full, overrun, frame_err;

  uart_rx_fifo_if #(.DATA_W(DW)) bus();

  uart_rx_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .sync_clr    (sync_clr),
    .bus         (bus.slave),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .status_clr  (status_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: contents as a plain queue plus two sticky bits.
  byte unsigned mq[$];
  bit           m_ovr;
  bit           m_fe;

  typedef struct {
    bit           done;
    byte unsigned dat;
    bit           err;
    bit           rdy;
    bit           stclr;
    bit           sclr;
    int           e_cnt;
    bit           e_vld;
    byte unsigned e_dat;
    bit           e_ovr;
    bit           e_fe;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic model_step(input bit done, input byte unsigned d, input bit err,
                            input bit rdy, input bit sclr, input bit stclr);
    bit was_full, do_pop, do_push;
    if (sclr) begin
      model_clear();
      return;
    end
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && rdy;
    do_push  = done && (!was_full || do_pop);
    if (done && !do_push) m_ovr = 1'b1;
    else if (stclr)       m_ovr = 1'b0;
    if (err)              m_fe  = 1'b1;
    else if (stclr)       m_fe  = 1'b0;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(d);
  endtask

  task automatic check_model(input string tag);
    int sz;
    byte unsigned front;
    sz    = mq.size();
    front = (sz > 0) ? mq[0] : 8'h00;
    chk({tag, " count"},       32'(count),       32'(sz));
    chk({tag, " empty"},       32'(empty),       32'(sz == 0));
    chk({tag, " full"},        32'(full),        32'(sz == DEPTH));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(sz >= AF));
    chk({tag, " rd_valid"},    32'(bus.rd_valid), 32'(sz > 0));
    chk({tag, " rd_data"},     32'(bus.rd_data), 32'(front));
    chk({tag, " overrun"},     32'(overrun),     32'(m_ovr));
    chk({tag, " frame_err"},   32'(frame_err),   32'(m_fe));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then release pulses.
  task automatic cycle(input bit done, input byte unsigned d, input bit err,
                       input bit rdy, input bit sclr, input bit stclr);
    bus.rx_done  = done;
    bus.rx_data  = d;
    bus.rx_error = err;
    bus.rd_ready = rdy;
    sync_clr     = sclr;
    status_clr   = stclr;
    @(posedge clk);
    model_step(done, d, err, rdy, sclr, stclr);
    #1;
    bus.rx_done  = 1'b0;
    bus.rx_data  = '0;
    bus.rx_error = 1'b0;
    bus.rd_ready = 1'b0;
    sync_clr     = 1'b0;
    status_clr   = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " count"},       32'(count),        0);
    chk({tag, " rd_valid"},    32'(bus.rd_valid), 0);
    chk({tag, " rd_data"},     32'(bus.rd_data),  0);
    chk({tag, " empty"},       32'(empty),        1);
    chk({tag, " full"},        32'(full),         0);
    chk({tag, " almost_full"}, 32'(almost_full),  0);
    chk({tag, " overrun"},     32'(overrun),      0);
    chk({tag, " frame_err"},   32'(frame_err),    0);
  endtask

  initial begin
    byte unsigned last;
    //              done dat   err rdy stclr sclr | cnt vld dat   ovr fe
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'hA3, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h0F, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h77, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h12, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0};

    bus.rx_done  = 1'b0;
    bus.rx_data  = '0;
    bus.rx_error = 1'b0;
    bus.rd_ready = 1'b0;
    model_clear();

    // Reset state, held across an edge.
    @(posedge clk);
    #1;
    check_cleared("reset");
    areset_n = 1'b1;

    // Vector table: ordering, empty/read corners, status set/clear priority.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].done, tbl[i].dat, tbl[i].err, tbl[i].rdy, tbl[i].sclr, tbl[i].stclr);
      chk($sformatf("vec%0d count", i),     32'(count),         32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d rd_valid", i),  32'(bus.rd_valid),  32'(tbl[i].e_vld));
      chk($sformatf("vec%0d rd_data", i),   32'(bus.rd_data),   32'(tbl[i].e_dat));
      chk($sformatf("vec%0d overrun", i),   32'(overrun),       32'(tbl[i].e_ovr));
      chk($sformatf("vec%0d frame_err", i), 32'(frame_err),     32'(tbl[i].e_fe));
    end

    // Asynchronous reset mid-stream with count=5: outputs clear without an edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, byte'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_model("pre_arst");
    #1;
    areset_n = 1'b0;
    #1;
    check_cleared("arst");
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    model_clear();

    // Same scenario cleared by sync_clr over one edge, with a push pending.
    for (int i = 0; i < 5; i++) cycle(1'b1, byte'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cleared("sclr");

    // Fill to full, watching almost_full cross at 12, then overrun on a 17th byte.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, byte'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      check_model("fill");
      if (i == AF - 2) chk("af below level", 32'(almost_full), 0);
      if (i == AF - 1) chk("af at level",    32'(almost_full), 1);
    end
    chk("fill full", 32'(full), 1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun set", 32'(overrun), 1);
    chk("overrun count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain order", 32'(bus.rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      check_model("drain");
    end
    chk("drain empty", 32'(empty), 1);

    // Full with simultaneous push and pop: byte accepted, no overrun.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, byte'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full push+pop overrun", 32'(overrun), 0);
    chk("full push+pop count",   32'(count),   DEPTH);
    check_model("full_pp");
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      last = bus.rd_data;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      check_model("drain2");
    end
    chk("last entry", 32'(last), 32'h0000_00EE);

    // Wrap-around: steady push/pop pairs at occupancy 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, byte'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, byte'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0);
      check_model("wrap");
    end

    // Random traffic: first half biased toward filling, second half toward draining.
    for (int i = 0; i < 400; i++) begin
      bit rdy;
      rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(bit'($urandom_range(0, 1)), byte'($urandom_range(0, 255)),
            ($urandom_range(0, 9) == 0), rdy,
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
